ocr_multich_dt_relay: RTL and testbench

- Multi-channel definite-time overcurrent relay core; successor to the single-channel OCR pipeline.
- Computes a sliding-window mean-square of each channel's ADC stream and compares it against the pickup current squared. No square root is taken.
- Trips a channel after TRIP_DLY consecutive picked-up samples and latches the trip until cleared.
- Runs on clk_master. A sample strobe replaces the separate 800 Hz clock domain.

---
 rtl/ocr_multich_dt_relay_if.sv | 26 ++
 rtl/ocr_multich_dt_relay.sv | 161 ++++++++++++++++
 tb/tb_ocr_multich_dt_relay.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocr_multich_dt_relay_if.sv
// Bus bundle for the multi-channel definite-time overcurrent relay core.
// master drives samples/controls; slave (the relay) returns status.
interface ocr_multich_dt_relay_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_CH   = 3
) ();
  logic                     sample_valid;
  logic [N_CH*DATA_W-1:0]   adc_data_in;
  logic [DATA_W-1:0]        I_p;
  logic                     trip_clear;
  logic                     busy;
  logic [N_CH-1:0]          pickup_ch;
  logic [N_CH-1:0]          trip_ch;
  logic                     trip_signal;
  logic                     overrun;

  modport master (
    output sample_valid, adc_data_in, I_p, trip_clear,
    input  busy, pickup_ch, trip_ch, trip_signal, overrun
  );

  modport slave (
    input  sample_valid, adc_data_in, I_p, trip_clear,
    output busy, pickup_ch, trip_ch, trip_signal, overrun
  );
endinterface

// File: rtl/ocr_multich_dt_relay.sv
// Multi-channel definite-time overcurrent relay: sliding-window mean-square vs I_p^2, timed latched trip.
// Define OCR_HYST_EN for pickup dropout hysteresis at 87.5 % of the threshold.
module ocr_multich_dt_relay #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N_CH     = 3,
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned TRIP_DLY = 8
) (
  input  logic                   clk_master,
  input  logic                   reset,
  ocr_multich_dt_relay_if.slave  bus
);

  localparam int unsigned SQ_W   = 2 * DATA_W;
  localparam int unsigned SUM_W  = SQ_W + WIN_LOG2;
  localparam int unsigned DEPTH  = 2 ** WIN_LOG2;
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TMR_W  = $clog2(TRIP_DLY + 1);
  localparam int unsigned FILL_W = WIN_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQ   = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_CMP  = 2'd3;

  logic [1:0]               state_q, state_nxt;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] x_q [N_CH];
  logic [SUM_W-1:0]         thr_q;
  logic [SQ_W-1:0]          sq_q, old_q;
  logic [SUM_W-1:0]         sum_q [N_CH];
  logic [TMR_W-1:0]         tmr_q [N_CH];
  logic [WIN_LOG2-1:0]      wr_ptr_q;
  logic [FILL_W-1:0]        fill_q;
  logic                     busy_q, overrun_q, trip_signal_q;
  logic [N_CH-1:0]          pickup_q, trip_q;
  logic [SQ_W-1:0]          sq_mem [N_CH][DEPTH];

  logic                     last_ch_c, win_full_c, eval_c, pick_c;
  logic signed [SQ_W-1:0]   prod_c;
  logic [SQ_W-1:0]          sq_c, ip_sq_c;
  logic [SUM_W-1:0]         cur_sum_c;
  logic [TMR_W-1:0]         cur_tmr_c, tmr_nxt_c;
  logic [N_CH-1:0]          trip_nxt_c;
`ifdef OCR_HYST_EN
  logic [SUM_W-1:0]         drop_thr_c;
`endif

  assign bus.busy        = busy_q;
  assign bus.pickup_ch   = pickup_q;
  assign bus.trip_ch     = trip_q;
  assign bus.trip_signal = trip_signal_q;
  assign bus.overrun     = overrun_q;

  // State register
  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state: three steps per channel, back to idle after the last channel
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (bus.sample_valid) state_nxt = S_SQ;
      S_SQ:    state_nxt = S_UPD;
      S_UPD:   state_nxt = S_CMP;
      S_CMP:   state_nxt = last_ch_c ? S_IDLE : S_SQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Channel evaluation: the sample that completes the window is the first one judged
  always_comb begin
    last_ch_c  = (ch_q == CH_W'(N_CH - 1));
    win_full_c = (fill_q == FILL_W'(DEPTH));
    eval_c     = (fill_q >= FILL_W'(DEPTH - 1));
    prod_c     = SQ_W'(x_q[ch_q]) * SQ_W'(x_q[ch_q]);
    sq_c       = prod_c;
    ip_sq_c    = SQ_W'(bus.I_p) * SQ_W'(bus.I_p);
    cur_sum_c  = sum_q[ch_q];
    cur_tmr_c  = tmr_q[ch_q];
    pick_c     = 1'b0;
`ifdef OCR_HYST_EN
    drop_thr_c = thr_q - (thr_q >> 3);
    if (eval_c)
      pick_c = pickup_q[ch_q] ? (cur_sum_c > drop_thr_c) : (cur_sum_c > thr_q);
`else
    if (eval_c)
      pick_c = (cur_sum_c > thr_q);
`endif
    tmr_nxt_c = '0;
    if (pick_c)
      tmr_nxt_c = (cur_tmr_c == TMR_W'(TRIP_DLY)) ? cur_tmr_c : cur_tmr_c + TMR_W'(1);
    // A clear only releases channels that have dropped out; a new trip beats the clear
    trip_nxt_c = trip_q;
    if (bus.trip_clear)
      trip_nxt_c = trip_q & pickup_q;
    if ((state_q == S_CMP) && pick_c && (tmr_nxt_c == TMR_W'(TRIP_DLY)))
      trip_nxt_c[ch_q] = 1'b1;
  end

  // Datapath and status registers
  always_ff @(posedge clk_master or posedge reset) begin
    if (reset) begin
      ch_q          <= '0;
      thr_q         <= '0;
      sq_q          <= '0;
      old_q         <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      pickup_q      <= '0;
      trip_q        <= '0;
      trip_signal_q <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        x_q[c]   <= '0;
        sum_q[c] <= '0;
        tmr_q[c] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (bus.sample_valid) begin
          for (int unsigned c = 0; c < N_CH; c++)
            x_q[c] <= bus.adc_data_in[c*DATA_W +: DATA_W];
          thr_q  <= SUM_W'(ip_sq_c) << WIN_LOG2;
          ch_q   <= '0;
          busy_q <= 1'b1;
        end
        S_SQ: begin
          sq_q  <= sq_c;
          old_q <= win_full_c ? sq_mem[ch_q][wr_ptr_q] : '0;
        end
        S_UPD: sum_q[ch_q] <= sum_q[ch_q] + SUM_W'(sq_q) - SUM_W'(old_q);
        S_CMP: begin
          pickup_q[ch_q] <= pick_c;
          tmr_q[ch_q]    <= tmr_nxt_c;
          if (last_ch_c) begin
            wr_ptr_q <= wr_ptr_q + WIN_LOG2'(1);
            if (!win_full_c) fill_q <= fill_q + FILL_W'(1);
            busy_q   <= 1'b0;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        default: ;
      endcase
      if (bus.sample_valid && (state_q != S_IDLE)) overrun_q <= 1'b1;
      else if (bus.trip_clear)                     overrun_q <= 1'b0;
      trip_q        <= trip_nxt_c;
      trip_signal_q <= |trip_nxt_c;
    end
  end

  // Square history; contents only matter once the window has been filled
  always_ff @(posedge clk_master) begin
    if (state_q == S_UPD) sq_mem[ch_q][wr_ptr_q] <= sq_q;
  end

endmodule

// File: tb/tb_ocr_multich_dt_relay.sv
// Self-checking bench for ocr_multich_dt_relay: table rows, hand sequences, and random
// stimulus against a sample-history reference model.
module tb_ocr_multich_dt_relay;
  localparam int DATA_W = 16;
  localparam int N_CH   = 3;
  localparam int WIN    = 16;
  localparam int DLY    = 8;
  localparam int LAT    = 3 * N_CH + 1;

  logic clk_master = 1'b0;
  logic reset;
  always #5 clk_master = ~clk_master;

  ocr_multich_dt_relay_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  ocr_multich_dt_relay #(.DATA_W(DATA_W), .N_CH(N_CH), .WIN_LOG2(4), .TRIP_DLY(DLY)) dut (
    .clk_master (clk_master),
    .reset      (reset),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: raw sample history per channel
  int              hist [N_CH][WIN];
  int              cnt  [N_CH];
  int              tmr  [N_CH];
  logic [N_CH-1:0] m_pick, m_trip;
  logic            m_ovr;

  typedef struct {
    int         v0, v1, v2;
    int         ip;
    int         reps;
    bit         rst;
    bit         clr;
    logic [2:0] pick;
    logic [2:0] trip;
  } row_t;

  row_t rows [12];
  int   sn   [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      cnt[c] = 0;
      tmr[c] = 0;
      for (int j = 0; j < WIN; j++) hist[c][j] = 0;
    end
    m_pick = '0;
    m_trip = '0;
    m_ovr  = 1'b0;
  endfunction

  function automatic void model_sample(input int s0, input int s1, input int s2, input int ip);
    longint thr;
    thr = longint'(ip) * longint'(ip) * WIN;
    for (int c = 0; c < N_CH; c++) begin
      int     v;
      int     n;
      longint sum;
      bit     pk;
      v = (c == 0) ? s0 : (c == 1) ? s1 : s2;
      hist[c][cnt[c] % WIN] = v;
      cnt[c]++;
      n   = (cnt[c] < WIN) ? cnt[c] : WIN;
      sum = 0;
      for (int j = 0; j < n; j++) sum += longint'(hist[c][j]) * longint'(hist[c][j]);
      pk = 1'b0;
      if (cnt[c] >= WIN) begin
`ifdef OCR_HYST_EN
        pk = m_pick[c] ? (sum > thr - thr / 8) : (sum > thr);
`else
        pk = (sum > thr);
`endif
      end
      m_pick[c] = pk;
      tmr[c] = pk ? ((tmr[c] < DLY) ? tmr[c] + 1 : DLY) : 0;
      if (tmr[c] == DLY) m_trip[c] = 1'b1;
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_pickup"},   bus.pickup_ch,   m_pick);
    chk({tag, "_trip"},     bus.trip_ch,     m_trip);
    chk({tag, "_tripsig"},  bus.trip_signal, |m_trip);
    chk({tag, "_overrun"},  bus.overrun,     m_ovr);
  endtask

  task automatic apply_sample(input int s0, input int s1, input int s2, input int ip, input bit dup);
    int k;
    @(negedge clk_master);
    bus.adc_data_in  = {16'(s2), 16'(s1), 16'(s0)};
    bus.I_p          = 16'(ip);
    bus.sample_valid = 1'b1;
    model_sample(s0, s1, s2, ip);
    @(negedge clk_master);
    bus.sample_valid = 1'b0;
    k = 1;
    chk("busy_after_strobe", bus.busy, 1);
    if (dup) begin
      @(negedge clk_master);
      k++;
      bus.adc_data_in  = {3{16'd30000}};
      bus.sample_valid = 1'b1;
      m_ovr = 1'b1;
      @(negedge clk_master);
      k++;
      bus.sample_valid = 1'b0;
    end
    while (bus.busy && k < 4 * LAT) begin
      @(negedge clk_master);
      k++;
    end
    chk("latency", k, LAT);
    check_outputs("sample");
  endtask

  task automatic pulse_clear();
    @(negedge clk_master);
    bus.trip_clear = 1'b1;
    @(negedge clk_master);
    bus.trip_clear = 1'b0;
    m_trip = m_trip & m_pick;
    m_ovr  = 1'b0;
    check_outputs("clear");
  endtask

  task automatic do_reset();
    @(negedge clk_master);
    reset = 1'b1;
    @(negedge clk_master);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pidx, tidx, a0, a1, a2, ip;
    logic [2:0] hyst_pick;
`ifdef OCR_HYST_EN
    hyst_pick = 3'b001;
`else
    hyst_pick = 3'b000;
`endif
    sn = '{0, 383, 707, 924, 1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383};
    //        v0    v1    v2    ip   reps rst clr pick    trip
    rows[0]  = '{0,    2000, 0,    2000, 16, 1, 0, 3'b000, 3'b000};
    rows[1]  = '{0,    2001, 0,    2000, 15, 1, 0, 3'b000, 3'b000};
    rows[2]  = '{0,    2001, 0,    2000, 1,  0, 0, 3'b010, 3'b000};
    rows[3]  = '{0,    2001, 0,    2000, 6,  0, 0, 3'b010, 3'b000};
    rows[4]  = '{0,    2001, 0,    2000, 1,  0, 0, 3'b010, 3'b010};
    rows[5]  = '{0,    0,    3000, 2000, 16, 1, 0, 3'b100, 3'b000};
    rows[6]  = '{0,    0,    3000, 2000, 7,  0, 0, 3'b100, 3'b100};
    rows[7]  = '{0,    0,    3000, 2000, 1,  0, 1, 3'b100, 3'b100};
    rows[8]  = '{0,    0,    0,    2000, 16, 0, 0, 3'b000, 3'b100};
    rows[9]  = '{0,    0,    0,    2000, 1,  0, 1, 3'b000, 3'b000};
    rows[10] = '{2100, 0,    0,    2000, 16, 1, 0, 3'b001, 3'b000};
    rows[11] = '{1950, 0,    0,    2000, 16, 0, 0, hyst_pick, 3'b001};

    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.adc_data_in  = '0;
    bus.I_p          = '0;
    bus.trip_clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_master);
    chk("reset_busy",    bus.busy,        0);
    chk("reset_pickup",  bus.pickup_ch,   0);
    chk("reset_trip",    bus.trip_ch,     0);
    chk("reset_tripsig", bus.trip_signal, 0);
    chk("reset_overrun", bus.overrun,     0);
    reset = 1'b0;

    // table-driven boundary, dropout/clear and hysteresis rows
    for (int i = 0; i < 12; i++) begin
      if (rows[i].rst) do_reset();
      for (int r = 0; r < rows[i].reps; r++)
        apply_sample(rows[i].v0, rows[i].v1, rows[i].v2, rows[i].ip, 1'b0);
      if (rows[i].clr) pulse_clear();
      chk($sformatf("row%0d_pick", i),    bus.pickup_ch,   rows[i].pick);
      chk($sformatf("row%0d_trip", i),    bus.trip_ch,     rows[i].trip);
      chk($sformatf("row%0d_tripsig", i), bus.trip_signal, |rows[i].trip);
    end

    // normal sinusoidal load then a fault at twice the amplitude on ch0
    do_reset();
    for (int i = 0; i < 64; i++) apply_sample(2000 * sn[i % 16] / 1000, 0, 0, 2000, 1'b0);
    chk("normal_pick",    bus.pickup_ch,   0);
    chk("normal_tripsig", bus.trip_signal, 0);
    pidx = -1;
    tidx = -1;
    for (int i = 0; i < 32; i++) begin
      apply_sample(4000 * sn[i % 16] / 1000, 0, 0, 2000, 1'b0);
      if (pidx < 0 && bus.pickup_ch[0]) pidx = i;
      if (tidx < 0 && bus.trip_ch[0])   tidx = i;
    end
    chk("fault_pick_in_window", (pidx >= 0 && pidx < WIN), 1);
    chk("fault_trip_gap",       tidx - pidx, DLY - 1);
    chk("fault_other_pick",     bus.pickup_ch[2:1], 0);
    chk("fault_other_trip",     bus.trip_ch[2:1],   0);
    chk("fault_tripsig",        bus.trip_signal,    1);

    // overrun: second strobe two cycles into the walk is dropped
    apply_sample(500, 600, 700, 2000, 1'b1);
    pulse_clear();
    apply_sample(500, 600, 700, 2000, 1'b0);

    // reset in the middle of a walk
    @(negedge clk_master);
    bus.adc_data_in  = {16'd100, 16'd100, 16'd100};
    bus.sample_valid = 1'b1;
    @(negedge clk_master);
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk_master);
    chk("pre_midreset_trip", bus.trip_ch[0], 1);
    reset = 1'b1;
    #1;
    chk("midreset_busy",    bus.busy,        0);
    chk("midreset_pickup",  bus.pickup_ch,   0);
    chk("midreset_trip",    bus.trip_ch,     0);
    chk("midreset_tripsig", bus.trip_signal, 0);
    chk("midreset_overrun", bus.overrun,     0);
    @(negedge clk_master);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < WIN; i++) apply_sample(3000, 0, 0, 1000, 1'b0);
    chk("refill_pick", bus.pickup_ch, 3'b001);

    // randomized blocks of varying amplitude with occasional clears
    for (int blk = 0; blk < 6; blk++) begin
      ip = int'($urandom_range(500, 3000));
      a0 = int'($urandom_range(ip / 2, 3 * ip));
      a1 = int'($urandom_range(ip / 2, 3 * ip));
      a2 = int'($urandom_range(ip / 2, 3 * ip));
      for (int i = 0; i < 32; i++) begin
        apply_sample(int'($urandom_range(0, 2 * a0)) - a0,
                     int'($urandom_range(0, 2 * a1)) - a1,
                     int'($urandom_range(0, 2 * a2)) - a2, ip, 1'b0);
        if ($urandom_range(0, 11) == 0) pulse_clear();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
